// File: rtl/freq_generator.sv
// ---------------------------------------------------------------------------
// freq_generator : burst/continuous square-wave generator, period 2*H cycles
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module freq_generator #(
    parameter int CNT_W  = 24,
    parameter int PCNT_W = 10
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [CNT_W-1:0]  HalfPeriod,
    input  logic [PCNT_W-1:0] PulseCount,
    output logic              Pulse,
    output logic              Busy,
    output logic              Finished,
    output logic [PCNT_W-1:0] SentCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  phase_cnt, phase_cnt_nxt;
    logic [CNT_W-1:0]  half_q, half_nxt;
    logic [PCNT_W-1:0] num_q, num_nxt;
    logic [PCNT_W-1:0] sent_nxt;
    logic              phase_end;

    // Phase counter runs 1..H inside a phase, so it never exceeds H and cannot wrap
    assign phase_end = (phase_cnt == half_q);

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        half_nxt      = half_q;
        num_nxt       = num_q;
        sent_nxt      = SentCount;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt     = HIGH;
                    half_nxt      = (HalfPeriod == '0) ? CNT_W'(1) : HalfPeriod;
                    num_nxt       = PulseCount;
                    sent_nxt      = PCNT_W'(1);
                    phase_cnt_nxt = CNT_W'(1);
                end
            end
            HIGH: begin
                if (!Start) begin
                    state_nxt     = IDLE;
                    phase_cnt_nxt = '0;
                end else if (phase_end) begin
                    state_nxt     = LOW;
                    phase_cnt_nxt = CNT_W'(1);
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_W'(1);
                end
            end
            LOW: begin
                if (!Start) begin
                    state_nxt     = IDLE;
                    phase_cnt_nxt = '0;
                end else if (phase_end) begin
                    if ((num_q != '0) && (SentCount == num_q)) begin
                        state_nxt     = DONE;
                        phase_cnt_nxt = '0;
                    end else begin
                        state_nxt     = HIGH;
                        phase_cnt_nxt = CNT_W'(1);
                        sent_nxt      = SentCount + PCNT_W'(1);
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (!Start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                phase_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            half_q    <= CNT_W'(1);
            num_q     <= '0;
            SentCount <= '0;
            Pulse     <= 1'b0;
            Busy      <= 1'b0;
            Finished  <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
            half_q    <= half_nxt;
            num_q     <= num_nxt;
            SentCount <= sent_nxt;
            Pulse     <= (state_nxt == HIGH);
            Busy      <= (state_nxt == HIGH) || (state_nxt == LOW);
            Finished  <= (state_nxt == DONE);
        end
    end

endmodule

`default_nettype wire

// File: doc/freq_generator.md
FREQ_GENERATOR -- requirements
Module: freq_generator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24, the half-period counter width in bits.
REQ-002 The block SHALL have parameter PCNT_W, default 10, the pulse-count width in bits.
REQ-003 Port CLK  input  1  system clock; all logic is on the rising edge.
REQ-004 Port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port Start  input  1  level request; high runs the generator, low aborts or acknowledges completion.
REQ-006 Port HalfPeriod  input  CNT_W  number of CLK cycles per high phase and per low phase.
REQ-007 Port PulseCount  input  PCNT_W  number of pulses in a burst; 0 selects continuous mode.
REQ-008 Port Pulse  output  1  generated square wave, registered, suitable as a sensor-output emulator.
REQ-009 Port Busy  output  1  high while in HIGH or LOW state.
REQ-010 Port Finished  output  1  high in DONE state only.
REQ-011 Port SentCount  output  PCNT_W  number of rising edges of Pulse issued in the current or last run.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, HIGH, LOW, DONE.
REQ-013 IDLE with Start=1 SHALL go to HIGH on the next edge, and SHALL latch H = max(HalfPeriod,1) and N = PulseCount in that same edge.
REQ-014 The latched H and N SHALL NOT change until the next IDLE->HIGH transition; HalfPeriod and PulseCount changes mid-run SHALL be ignored.
REQ-015 On every entry to HIGH, Pulse SHALL be 1 in that same edge and SentCount SHALL increment by 1; on IDLE->HIGH, SentCount SHALL first clear, so it reads 1.
REQ-016 HIGH and LOW SHALL each last exactly H cycles, giving a Pulse period of 2*H cycles and a frequency of CLK/(2*H).
REQ-017 At the end of HIGH, the FSM SHALL go to LOW and Pulse SHALL be 0.
REQ-018 At the end of LOW with N != 0 and SentCount == N, the FSM SHALL go to DONE; otherwise it SHALL go to HIGH.
REQ-019 With N = 0, the FSM SHALL never enter DONE, and SentCount SHALL wrap from 2^PCNT_W-1 to 0.
REQ-020 In DONE, Finished SHALL be 1, Busy 0 and Pulse 0; the FSM SHALL stay in DONE while Start=1.
REQ-021 DONE with Start=0 SHALL go to IDLE on the next edge, and Finished SHALL clear in that same edge.
REQ-022 Start=0 in HIGH or LOW (abort) SHALL go to IDLE on the next edge with Pulse=0 and Busy=0; Finished SHALL stay 0.
REQ-023 On abort, SentCount SHALL hold its value.
REQ-024 SentCount SHALL hold its value in IDLE and DONE until the next IDLE->HIGH transition.
REQ-025 Start=1 held through DONE->IDLE SHALL NOT restart the generator until Start has been seen low.
REQ-026 Busy and Finished SHALL never be 1 in the same cycle.
REQ-027 The phase counter SHALL be CNT_W bits wide and SHALL never wrap within a phase.
REQ-028 The maximum H SHALL be 2^CNT_W-1.

Reset
REQ-029 Rst_n=0 SHALL immediately force: state IDLE, Pulse=0, Busy=0, Finished=0, SentCount=0, phase counter 0, latched H=1, latched N=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no further Pulse edges.
REQ-031 After Rst_n rises, the block SHALL take no action until Start is sampled high in IDLE.

Verification
REQ-032 Burst: H=4, N=3, Start rises at cycle 0 -> Pulse high in cycles 1-4, 9-12 and 17-20, low otherwise; SentCount reads 1, 2, 3; Finished=1 from cycle 25; Busy=1 in cycles 1-24.
REQ-033 Minimum period: HalfPeriod=0, N=0 -> behaves identically to HalfPeriod=1, with Pulse toggling every cycle; after 1024 pulses, SentCount returns to 0.
REQ-034 Abort: H=10, N=5, Start drops in cycle 23 -> Pulse=0, Busy=0 and Finished=0 from cycle 24, with SentCount=2 held.
REQ-035 Mid-run changes: HalfPeriod changed 4->7 during a burst -> period stays 8 cycles; the next run, after Start low then high, uses a 14-cycle period.
REQ-036 Reset mid-run: Rst_n pulsed low in a HIGH phase -> all outputs 0 asynchronously; no Pulse edge after release until the next Start.
REQ-037 Loopback: Pulse driven into the team's sensor frequency counter (6,250,000-cycle window), H=3125, N=0 -> the counter reports 1000 +/-1.
